// File: rtl/mult_div_unit.sv
// Iterative 32-step multiply/divide unit with architectural HI/LO registers.
// Ports:
//   clk, reset    : clock and synchronous active-high reset
//   start, op     : one-cycle request and its operation code
//   SrcA, SrcB    : operands (multiplicand/dividend/move data, multiplier/divisor)
//   busy, done    : iteration in progress / one-cycle result-written pulse
//   HI, LO        : registered result registers
module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2*W-1:0] acc;
    logic [W-1:0]  dvsr;
    logic [W-1:0]  orig_a;
    logic          is_div;
    logic          neg_res;
    logic          neg_rem;
    logic          div_zero;

    // Request decode
    logic          op_md;
    logic          op_mthi;
    logic          op_mtlo;
    logic          op_sgn;
    logic          a_neg;
    logic          b_neg;
    logic [W-1:0]  a_mag;
    logic [W-1:0]  b_mag;

    always_comb begin
        op_md   = (op[2] == 1'b0);
        op_mthi = (op == 3'b100);
        op_mtlo = (op == 3'b101);
        op_sgn  = op_md && !op[0];
        a_neg   = op_sgn && SrcA[W-1];
        b_neg   = op_sgn && SrcB[W-1];
        a_mag   = a_neg ? (~SrcA + 1'b1) : SrcA;
        b_mag   = b_neg ? (~SrcB + 1'b1) : SrcB;
    end

    // One iteration step.
    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     div_shift;
    logic           div_ge;
    logic [W:0]     div_rem;
    logic [2*W-1:0] div_next;
    logic [2*W-1:0] acc_next;

    always_comb begin
        mul_sum = {1'b0, acc[2*W-1:W]};
        if (acc[0]) begin
            mul_sum = mul_sum + {1'b0, dvsr};
        end
        mul_next  = {mul_sum, acc[W-1:1]};

        div_shift = {acc[2*W-1:W], acc[W-1]};
        div_ge    = (div_shift >= {1'b0, dvsr});
        div_rem   = div_ge ? (div_shift - {1'b0, dvsr}) : div_shift;
        div_next  = {div_rem[W-1:0], acc[W-2:0], div_ge};

        acc_next  = is_div ? div_next : mul_next;
    end

    // Sign fix-up applied on the final iteration. Divide by zero bypasses
    // the fix-up so the quotient is all ones and HI is the raw dividend.
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo;
    logic [W-1:0]   rem;
    logic [W-1:0]   fin_hi;
    logic [W-1:0]   fin_lo;

    always_comb begin
        prod = neg_res ? (~acc_next + 1'b1) : acc_next;
        quo  = neg_res ? (~acc_next[W-1:0] + 1'b1) : acc_next[W-1:0];
        rem  = neg_rem ? (~acc_next[2*W-1:W] + 1'b1) : acc_next[2*W-1:W];
        if (!is_div) begin
            fin_hi = prod[2*W-1:W];
            fin_lo = prod[W-1:0];
        end else if (div_zero) begin
            fin_hi = orig_a;
            fin_lo = '1;
        end else begin
            fin_hi = rem;
            fin_lo = quo;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            dvsr     <= '0;
            orig_a   <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            HI       <= '0;
            LO       <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && op_md) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        orig_a   <= SrcA;
                        is_div   <= op[1];
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= op[1] && a_neg;
                        div_zero <= op[1] && (SrcB == '0);
                        if (op[1]) begin
                            acc  <= {{W{1'b0}}, a_mag};
                            dvsr <= b_mag;
                        end else begin
                            acc  <= {{W{1'b0}}, b_mag};
                            dvsr <= a_mag;
                        end
                    end else if (start && op_mthi) begin
                        HI <= SrcA;
                    end else if (start && op_mtlo) begin
                        LO <= SrcA;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        HI    <= fin_hi;
                        LO    <= fin_lo;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed table, corner sequences
// and randomized operations against an arithmetic reference model.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks;
    int errors;

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .SrcA (SrcA),
        .SrcB (SrcB),
        .busy (busy),
        .done (done),
        .HI   (HI),
        .LO   (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: {HI, LO} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] t;
        logic [63:0] tq;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            3'd0: begin
                t = sa * sb;
                return t;
            end
            3'd1: return ua * ub;
            3'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q  = sa / sb;
                r  = sa % sb;
                t  = r;
                tq = q;
                return {t[31:0], tq[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                t  = ua % ub;
                tq = ua / ub;
                return {t[31:0], tq[31:0]};
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a request; returns just after the accept edge.
    task automatic start_op(input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] b);
        start = 1'b1;
        op    = o;
        SrcA  = a;
        SrcB  = b;
        tick();
        start = 1'b0;
        op    = 3'b110;
    endtask

    // Wait for done, bounded; checks busy stays high and latency.
    task automatic wait_done(input int exp_lat, input string name);
        int n;
        int bad;
        n   = 0;
        bad = 0;
        while (n < 40) begin
            tick();
            n++;
            if (done) break;
            if (!busy) bad++;
        end
        check({name, "_latency"}, 64'(n), 64'(exp_lat));
        check({name, "_busy_gap"}, 64'(bad), 64'd0);
        check({name, "_busy_at_done"}, {63'b0, busy}, 64'd0);
    endtask

    initial begin
        logic [63:0] exp;
        logic [31:0] hold_hi;
        logic [31:0] hold_lo;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          seen;

        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        op     = 3'b110;
        SrcA   = '0;
        SrcB   = '0;

        vecs[0] = '{3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1};
        vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{3'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF};
        vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000};
        vecs[5] = '{3'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[6] = '{3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD};
        vecs[7] = '{3'd3, 32'd100, 32'd7, 32'd2, 32'd14};
        vecs[8] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
        vecs[9] = '{3'd0, 32'd6, 32'd7, 32'd0, 32'd42};

        tick();
        tick();
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_hi", {32'b0, HI}, 64'd0);
        check("reset_lo", {32'b0, LO}, 64'd0);
        reset = 1'b0;
        tick();

        // Directed table, issued back to back (start at the done-drop edge).
        for (int i = 0; i < 10; i++) begin
            hold_hi = HI;
            hold_lo = LO;
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_accept", i), {62'b0, busy, done}, 64'd2);
            check($sformatf("vec%0d_hold", i), {HI, LO}, {hold_hi, hold_lo});
            wait_done(32, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_hi", i), {32'b0, HI}, {32'b0, vecs[i].hi});
            check($sformatf("vec%0d_lo", i), {32'b0, LO}, {32'b0, vecs[i].lo});
        end
        tick();
        check("done_drop", {62'b0, busy, done}, 64'd0);

        // MTHI then MTLO on consecutive cycles.
        seen  = 0;
        start = 1'b1;
        op    = 3'b100;
        SrcA  = 32'h1234_5678;
        tick();
        seen += busy | done;
        check("mthi_hi", {32'b0, HI}, 64'h1234_5678);
        check("mthi_lo_kept", {32'b0, LO}, 64'd42);
        op   = 3'b101;
        SrcA = 32'h9ABC_DEF0;
        tick();
        seen += busy | done;
        start = 1'b0;
        tick();
        seen += busy | done;
        check("mt_hi", {32'b0, HI}, 64'h1234_5678);
        check("mt_lo", {32'b0, LO}, 64'h9ABC_DEF0);
        check("mt_no_busy_done", 64'(seen), 64'd0);

        // No-op codes leave everything untouched.
        start = 1'b1;
        op    = 3'b110;
        SrcA  = 32'h5555_5555;
        tick();
        op = 3'b111;
        tick();
        start = 1'b0;
        tick();
        check("noop_state", {62'b0, busy, done}, 64'd0);
        check("noop_hilo", {HI, LO}, {32'h1234_5678, 32'h9ABC_DEF0});

        // MTLO while busy is dropped, not queued.
        start_op(3'd3, 32'd100, 32'd7);
        repeat (9) tick();
        start = 1'b1;
        op    = 3'b101;
        SrcA  = 32'h0000_DEAD;
        tick();
        start = 1'b0;
        check("busy_mtlo_ignored", {32'b0, LO}, 64'h9ABC_DEF0);
        wait_done(22, "divu_busy");
        check("divu_busy_lo", {32'b0, LO}, 64'd14);
        check("divu_busy_hi", {32'b0, HI}, 64'd2);
        tick();
        tick();
        check("divu_busy_lo_after", {32'b0, LO}, 64'd14);

        // Reset in the middle of a multiply.
        start_op(3'd0, 32'd6, 32'd7);
        repeat (14) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_state", {62'b0, busy, done}, 64'd0);
        check("midreset_hilo", {HI, LO}, 64'd0);
        seen = 0;
        repeat (24) begin
            tick();
            seen += busy | done;
        end
        check("midreset_quiet", 64'(seen), 64'd0);
        start_op(3'd0, 32'd6, 32'd7);
        wait_done(32, "mult_after_reset");
        check("mult_after_reset", {HI, LO}, 64'd42);

        // Reset wins over start on the same edge.
        reset = 1'b1;
        start = 1'b1;
        op    = 3'b100;
        SrcA  = 32'hABCD_0123;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("reset_prio_state", {62'b0, busy, done}, 64'd0);
        check("reset_prio_hilo", {HI, LO}, 64'd0);

        // Randomized operations against the model.
        for (int k = 0; k < 40; k++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: begin
                    ra = 32'h8000_0000;
                    rb = 32'hFFFF_FFFF;
                end
                3: ra = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            exp = model(ro, ra, rb);
            start_op(ro, ra, rb);
            wait_done(32, $sformatf("rnd%0d", k));
            check($sformatf("rnd%0d_op%0d_%h_%h", k, ro, ra, rb), {HI, LO}, exp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
